// File: rtl/prog_loader_if.sv
// prog_loader_if
// Instruction-word stream into the program loader.
//   in_valid  source has a word on in_data
//   in_data   instruction word (DATA_W bits)
//   in_last   marks the final word of a program, qualified by the handshake
//   in_ready  loader can accept a word this cycle
// Modports: master = word source, slave = loader.
interface prog_loader_if #(
    parameter int DATA_W = 32
) ();
    logic              in_valid;
    logic [DATA_W-1:0] in_data;
    logic              in_last;
    logic              in_ready;

    modport master (
        output in_valid,
        output in_data,
        output in_last,
        input  in_ready
    );

    modport slave (
        input  in_valid,
        input  in_data,
        input  in_last,
        output in_ready
    );
endinterface

// File: rtl/prog_loader.sv
// prog_loader
// Front-end for the single-cycle CPU. It streams instruction words into
// instruction memory from address 0, pulses startin once the program is
// loaded, lets the CPU run for RUN_CYCLES clocks, then flags done.
// Ports:
//   clk, rst      system clock, synchronous active-high reset
//   in_if         word stream (slave side of prog_loader_if)
//   mem_we        instruction-memory write enable
//   mem_addr      instruction-memory word address
//   mem_wdata     instruction-memory write data
//   startin       one-cycle CPU start pulse
//   busy          high while loading, starting or running
//   done          program has run RUN_CYCLES cycles (held until next load)
//   err           program was truncated at DEPTH words
//   word_count    words written in the current/last load
//
// state | meaning
// ------+----------------------------------------------------------
// IDLE  | after reset, waiting for the first word
// LOAD  | writing words at ptr until in_last or memory is full
// START | one cycle, startin asserted alongside the final write
// RUN   | CPU executing, run_cnt counts 0 .. RUN_CYCLES-1
// DONE  | run complete; a new handshake starts a fresh load
module prog_loader #(
    parameter int ADDR_W     = 6,
    parameter int DATA_W     = 32,
    parameter int RUN_CYCLES = 21
) (
    input  logic              clk,
    input  logic              rst,
    prog_loader_if.slave      in_if,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              startin,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [ADDR_W:0]   word_count
);

    localparam int CNT_W = (RUN_CYCLES > 1) ? $clog2(RUN_CYCLES) : 1;

    localparam logic [ADDR_W-1:0] PTR_LAST = ADDR_W'((2 ** ADDR_W) - 1);
    localparam logic [ADDR_W-1:0] PTR_ONE  = ADDR_W'(1);
    localparam logic [ADDR_W:0]   WC_ONE   = (ADDR_W + 1)'(1);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(RUN_CYCLES - 1);
    localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_START,
        ST_RUN,
        ST_DONE
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [ADDR_W-1:0] ptr;
    logic [CNT_W-1:0]  run_cnt;
    logic              ready;
    logic              hs;
    logic              first_word;
    logic              at_last_slot;

    assign ready          = (state == ST_IDLE) || (state == ST_LOAD) || (state == ST_DONE);
    assign in_if.in_ready = ready;
    assign hs             = in_if.in_valid && ready;
    // A load always restarts at address 0 when it begins from IDLE or DONE.
    assign first_word     = hs && ((state == ST_IDLE) || (state == ST_DONE));
    assign at_last_slot   = (ptr == PTR_LAST);

    assign startin = (state == ST_START);
    assign busy    = (state == ST_LOAD) || (state == ST_START) || (state == ST_RUN);
    assign done    = (state == ST_DONE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE, ST_DONE: begin
                if (hs) begin
                    state_nxt = in_if.in_last ? ST_START : ST_LOAD;
                end
            end
            ST_LOAD: begin
                // Filling the last slot without in_last truncates the program.
                if (hs && (in_if.in_last || at_last_slot)) begin
                    state_nxt = ST_START;
                end
            end
            ST_START: state_nxt = ST_RUN;
            ST_RUN: begin
                if (run_cnt == CNT_LAST) begin
                    state_nxt = ST_DONE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr        <= '0;
            run_cnt    <= '0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            err        <= 1'b0;
            word_count <= '0;
        end else begin
            mem_we <= hs;
            if (hs) begin
                mem_wdata <= in_if.in_data;
                mem_addr  <= first_word ? '0 : ptr;
            end

            if (first_word) begin
                ptr        <= PTR_ONE;
                word_count <= WC_ONE;
                err        <= 1'b0;
            end else if (hs) begin
                // ptr is held at the last slot so it never wraps within a load.
                if (!at_last_slot) begin
                    ptr <= ptr + PTR_ONE;
                end
                word_count <= word_count + WC_ONE;
                if (!in_if.in_last && at_last_slot) begin
                    err <= 1'b1;
                end
            end

            if (state == ST_START) begin
                run_cnt <= '0;
            end else if (state == ST_RUN) begin
                run_cnt <= run_cnt + CNT_ONE;
            end
        end
    end

endmodule

// File: tb/tb_prog_loader.sv
module tb_prog_loader;

    logic        clk;
    logic        rst;
    logic        mem_we;
    logic [5:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic        startin;
    logic        busy;
    logic        done;
    logic        err;
    logic [6:0]  word_count;

    int checks   = 0;
    int failures = 0;

    prog_loader_if #(.DATA_W(32)) bus ();

    prog_loader #(.ADDR_W(6), .DATA_W(32), .RUN_CYCLES(21)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_if      (bus),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .startin    (startin),
        .busy       (busy),
        .done       (done),
        .err        (err),
        .word_count (word_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_done(input int max_cycles);
        int n;
        n = 0;
        while (done !== 1'b1 && n < max_cycles) begin
            step();
            n++;
        end
        checks++;
        if (done !== 1'b1) begin
            failures++;
            $display("FAIL wait_done: done=%b after %0d cycles, required 1", done, n);
        end
    endtask

    task automatic test_reset();
        rst          = 1'b1;
        bus.in_valid = 1'b1;
        bus.in_data  = 32'hDEADBEEF;
        bus.in_last  = 1'b0;
        repeat (2) begin
            step();
            checks++;
            if ({mem_we, startin, busy, done, err} !== 5'b0) begin
                failures++;
                $display("FAIL reset_flags: we/start/busy/done/err=%b required 00000",
                         {mem_we, startin, busy, done, err});
            end
            checks++;
            if (mem_addr !== 6'd0 || mem_wdata !== 32'd0 || word_count !== 7'd0) begin
                failures++;
                $display("FAIL reset_regs: addr=%0h wdata=%0h wc=%0d required 0/0/0",
                         mem_addr, mem_wdata, word_count);
            end
            checks++;
            if (bus.in_ready !== 1'b1) begin
                failures++;
                $display("FAIL reset_ready: in_ready=%b required 1", bus.in_ready);
            end
        end
        rst          = 1'b0;
        bus.in_valid = 1'b0;
        step();
        checks++;
        if (bus.in_ready !== 1'b1 || mem_we !== 1'b0) begin
            failures++;
            $display("FAIL reset_release: in_ready=%b mem_we=%b required 1/0",
                     bus.in_ready, mem_we);
        end
    endtask

    task automatic test_load4();
        logic [31:0] w [4];
        w[0] = 32'h20110005;
        w[1] = 32'h20120007;
        w[2] = 32'h02328820;
        w[3] = 32'hAC110000;
        for (int i = 0; i < 4; i++) begin
            bus.in_valid = 1'b1;
            bus.in_data  = w[i];
            bus.in_last  = (i == 3);
            step();
            checks++;
            if (mem_we !== 1'b1 || mem_addr !== 6'(i) || mem_wdata !== w[i]) begin
                failures++;
                $display("FAIL load4_write%0d: we=%b addr=%0d data=%h required 1/%0d/%h",
                         i, mem_we, mem_addr, mem_wdata, i, w[i]);
            end
            checks++;
            if (startin !== (i == 3) || busy !== 1'b1) begin
                failures++;
                $display("FAIL load4_start%0d: startin=%b busy=%b required %0b/1",
                         i, startin, busy, (i == 3));
            end
        end
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
        checks++;
        if (bus.in_ready !== 1'b0 || word_count !== 7'd4 || err !== 1'b0) begin
            failures++;
            $display("FAIL load4_status: ready=%b wc=%0d err=%b required 0/4/0",
                     bus.in_ready, word_count, err);
        end
        for (int k = 0; k < 21; k++) begin
            step();
            checks++;
            if (startin !== 1'b0 || busy !== 1'b1 || done !== 1'b0 || mem_we !== 1'b0) begin
                failures++;
                $display("FAIL load4_run%0d: start=%b busy=%b done=%b we=%b required 0/1/0/0",
                         k, startin, busy, done, mem_we);
            end
        end
        step();
        checks++;
        if (done !== 1'b1 || busy !== 1'b0 || bus.in_ready !== 1'b1) begin
            failures++;
            $display("FAIL load4_done: done=%b busy=%b ready=%b required 1/0/1",
                     done, busy, bus.in_ready);
        end
        checks++;
        if (word_count !== 7'd4 || err !== 1'b0) begin
            failures++;
            $display("FAIL load4_final: wc=%0d err=%b required 4/0", word_count, err);
        end
    endtask

    task automatic test_gapped();
        logic [31:0] d;
        for (int i = 0; i < 3; i++) begin
            d            = 32'hA0000001 + 32'(i);
            bus.in_valid = 1'b1;
            bus.in_data  = d;
            bus.in_last  = (i == 2);
            step();
            checks++;
            if (mem_we !== 1'b1 || mem_addr !== 6'(i) || mem_wdata !== d) begin
                failures++;
                $display("FAIL gapped_write%0d: we=%b addr=%0d data=%h required 1/%0d/%h",
                         i, mem_we, mem_addr, mem_wdata, i, d);
            end
            if (i == 0) begin
                checks++;
                if (done !== 1'b0 || err !== 1'b0 || word_count !== 7'd1) begin
                    failures++;
                    $display("FAIL gapped_clear: done=%b err=%b wc=%0d required 0/0/1",
                             done, err, word_count);
                end
            end
            bus.in_valid = 1'b0;
            bus.in_last  = 1'b0;
            bus.in_data  = 32'hFFFFFFFF;
            step();
            checks++;
            if (mem_we !== 1'b0 || mem_addr !== 6'(i) || mem_wdata !== d) begin
                failures++;
                $display("FAIL gapped_hold%0d: we=%b addr=%0d data=%h required 0/%0d/%h",
                         i, mem_we, mem_addr, mem_wdata, i, d);
            end
        end
        wait_done(40);
        checks++;
        if (word_count !== 7'd3 || err !== 1'b0) begin
            failures++;
            $display("FAIL gapped_count: wc=%0d err=%b required 3/0", word_count, err);
        end
    endtask

    task automatic test_overflow();
        logic [31:0] d;
        for (int i = 0; i < 64; i++) begin
            checks++;
            if (bus.in_ready !== 1'b1) begin
                failures++;
                $display("FAIL ovf_ready%0d: in_ready=%b required 1", i, bus.in_ready);
            end
            d            = 32'h10000000 + 32'(i);
            bus.in_valid = 1'b1;
            bus.in_data  = d;
            bus.in_last  = 1'b0;
            step();
            checks++;
            if (mem_we !== 1'b1 || mem_addr !== 6'(i) || mem_wdata !== d) begin
                failures++;
                $display("FAIL ovf_write%0d: we=%b addr=%0d data=%h required 1/%0d/%h",
                         i, mem_we, mem_addr, mem_wdata, i, d);
            end
        end
        checks++;
        if (startin !== 1'b1 || err !== 1'b1 || word_count !== 7'd64 || bus.in_ready !== 1'b0) begin
            failures++;
            $display("FAIL ovf_status: start=%b err=%b wc=%0d ready=%b required 1/1/64/0",
                     startin, err, word_count, bus.in_ready);
        end
        bus.in_data = 32'h10000040;
        step();
        checks++;
        if (mem_we !== 1'b0 || mem_addr !== 6'd63 || mem_wdata !== 32'h1000003F) begin
            failures++;
            $display("FAIL ovf_reject: we=%b addr=%0d data=%h required 0/63/1000003f",
                     mem_we, mem_addr, mem_wdata);
        end
        bus.in_valid = 1'b0;
        wait_done(40);
        checks++;
        if (err !== 1'b1 || word_count !== 7'd64) begin
            failures++;
            $display("FAIL ovf_final: err=%b wc=%0d required 1/64", err, word_count);
        end
    endtask

    task automatic test_reload();
        bus.in_valid = 1'b1;
        bus.in_data  = 32'h00000000;
        bus.in_last  = 1'b1;
        step();
        checks++;
        if (mem_we !== 1'b1 || mem_addr !== 6'd0 || mem_wdata !== 32'd0) begin
            failures++;
            $display("FAIL reload_write: we=%b addr=%0d data=%h required 1/0/0",
                     mem_we, mem_addr, mem_wdata);
        end
        checks++;
        if (word_count !== 7'd1 || err !== 1'b0 || done !== 1'b0 || startin !== 1'b1) begin
            failures++;
            $display("FAIL reload_status: wc=%0d err=%b done=%b start=%b required 1/0/0/1",
                     word_count, err, done, startin);
        end
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
        for (int k = 0; k < 21; k++) begin
            step();
            checks++;
            if (done !== 1'b0 || startin !== 1'b0) begin
                failures++;
                $display("FAIL reload_run%0d: done=%b start=%b required 0/0", k, done, startin);
            end
        end
        step();
        checks++;
        if (done !== 1'b1) begin
            failures++;
            $display("FAIL reload_done: done=%b required 1", done);
        end
    endtask

    task automatic test_midrun_reset();
        bus.in_valid = 1'b1;
        bus.in_data  = 32'h12345678;
        bus.in_last  = 1'b1;
        step();
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
        repeat (5) step();
        checks++;
        if (busy !== 1'b1 || startin !== 1'b0) begin
            failures++;
            $display("FAIL midrun_running: busy=%b start=%b required 1/0", busy, startin);
        end
        rst = 1'b1;
        step();
        checks++;
        if ({busy, done, startin, mem_we, err} !== 5'b0 || word_count !== 7'd0) begin
            failures++;
            $display("FAIL midrun_reset: busy/done/start/we/err=%b wc=%0d required 00000/0",
                     {busy, done, startin, mem_we, err}, word_count);
        end
        rst = 1'b0;
        for (int i = 0; i < 2; i++) begin
            bus.in_valid = 1'b1;
            bus.in_data  = 32'h55000000 + 32'(i);
            bus.in_last  = (i == 1);
            step();
            checks++;
            if (mem_we !== 1'b1 || mem_addr !== 6'(i) || mem_wdata !== 32'h55000000 + 32'(i)) begin
                failures++;
                $display("FAIL midrun_reload%0d: we=%b addr=%0d data=%h required 1/%0d/%h",
                         i, mem_we, mem_addr, mem_wdata, i, 32'h55000000 + 32'(i));
            end
        end
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
        wait_done(40);
        checks++;
        if (word_count !== 7'd2) begin
            failures++;
            $display("FAIL midrun_count: wc=%0d required 2", word_count);
        end
    endtask

    initial begin
        rst          = 1'b1;
        bus.in_valid = 1'b0;
        bus.in_data  = 32'h0;
        bus.in_last  = 1'b0;
        test_reset();
        test_load4();
        test_gapped();
        test_overflow();
        test_reload();
        test_midrun_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/prog_loader.md
Name: prog_loader

Overview:
- Front-end for the single-cycle CPU top.
- Accepts a stream of 32-bit instruction words over a valid/ready handshake and writes them sequentially into instruction memory from address 0.
- After loading, issues the one-cycle `startin` pulse to the CPU, then counts a fixed number of run cycles and flags completion.
- It sits on the write/launch side of the CPU, opposite the register-read (`regNo`/`val`) debug side.

Parameters:
- ADDR_W, 6, instruction-memory word-address width; DEPTH = 2**ADDR_W words.
- DATA_W, 32, instruction word width.
- RUN_CYCLES, 21, clk cycles the CPU runs after `startin` before `done`.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  source has a word on in_data.
- in_data  input  DATA_W  instruction word.
- in_last  input  1  marks final word of program; qualified by handshake.
- in_ready  output  1  loader accepts a word this cycle.
- mem_we  output  1  instruction-memory write enable.
- mem_addr  output  ADDR_W  instruction-memory word address.
- mem_wdata  output  DATA_W  instruction-memory write data.
- startin  output  1  CPU start pulse.
- busy  output  1  high in LOAD, START, RUN.
- done  output  1  program has run RUN_CYCLES cycles; sticky.
- err  output  1  program truncated at DEPTH words; sticky until next load or rst.
- word_count  output  ADDR_W+1  words written in current/last load.

Behaviour:
- Reset: rst sampled high at an edge forces state IDLE and clears the write pointer and run counter. All registered outputs go to 0 the next cycle: mem_we, mem_addr, mem_wdata, startin, busy, done, err, word_count.
- Reset mid-operation: aborts load or run. Memory words already written are not undone.
- A handshake occurs when in_valid && in_ready at a rising edge.
- in_ready is combinational from state: 1 in IDLE, LOAD and DONE; 0 in START and RUN.
- States:
  - IDLE: handshake → write word, ptr=1, word_count=1, err=0 → LOAD. If in_last is also high, go to START instead.
  - LOAD: each handshake writes at ptr, then ptr++ and word_count++. A handshake with in_last=1 → START. A handshake at ptr=DEPTH-1 with in_last=0 writes the word, sets err=1 → START (truncation).
  - START: exactly one cycle. startin=1 for that cycle only; busy=1 → RUN, run counter=0.
  - RUN: counter increments each cycle. When it reaches RUN_CYCLES-1 → DONE. Total RUN residency is RUN_CYCLES cycles.
  - DONE: done=1, busy=0. A handshake starts a new load exactly as from IDLE: done cleared, err cleared, ptr restarts at 0.
- Write latency:
  - The write for a handshake at edge N appears as mem_we=1, mem_addr=ptr, mem_wdata=in_data during cycle N+1.
  - mem_we is 0 in every cycle without a preceding handshake.
  - mem_addr and mem_wdata hold their last value when mem_we=0.
- Timing from the final handshake (at edge N):
  - Last write appears in cycle N+1.
  - State is START in cycle N+1, so startin is coincident with the last write. This is allowed because the CPU samples startin at the following edge, after the memory write has committed.
  - RUN occupies cycles N+2 .. N+1+RUN_CYCLES; done=1 from cycle N+2+RUN_CYCLES.
- word_count saturates at DEPTH; the pointer never wraps within one load.
- in_valid while in_ready=0 has no effect; data is not captured.
- rst and a handshake in the same cycle: rst wins; the word is dropped.

Test Plan:
- Reset: hold rst 2 cycles with in_valid=1 → all outputs 0, no mem_we, state IDLE; release → in_ready=1.
- Load 4 words 0x20110005, 0x20120007, 0x02328820, 0xAC110000, the last with in_last=1, back-to-back → mem_we pulses at addr 0..3 with matching data. startin high exactly 1 cycle, coincident with the addr-3 write. word_count=4, done rises 21 cycles after startin falls, err=0.
- Gapped load: in_valid toggling 1/0 with 3 words → writes only on handshake cycles, addresses 0,1,2 contiguous, no duplicate writes.
- Overflow: 65 words with ADDR_W=6 and no in_last → 64 writes (addr 0..63). in_ready=0 after the 64th handshake, so the 65th is not accepted. err=1, word_count=64, startin still issued.
- Reload from DONE: single word 0x00000000 with in_last=1 → done and err clear, write at addr 0, word_count=1, new startin pulse, done again after 21 cycles.
- Mid-run reset: assert rst 5 cycles into RUN → busy=0, done=0, startin=0 next cycle. A subsequent load restarts at addr 0.
